// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment display.
// It samples the anode and segment lines and rebuilds the four hex characters being shown.
module seg7_scan_decoder #(
   parameter int MIN_HOLD = 16,
   parameter int TIMEOUT  = 65536,
   parameter int CNT_W    = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       an3,
   input  logic       an2,
   input  logic       an1,
   input  logic       an0,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   output logic [3:0] char3,
   output logic [3:0] char2,
   output logic [3:0] char1,
   output logic [3:0] char0,
   output logic [3:0] char_valid,
   output logic       frame_done,
   output logic       err_multi,
   output logic       err_seg
);

   typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

   // Both fire thresholds sit one below the visible count because the output register adds a cycle.
   localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(MIN_HOLD - 2);
   localparam logic [CNT_W-1:0] TO_FIRE   = CNT_W'(TIMEOUT - 2);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Returns {legal, value}; the segment pattern is active low, ordered g..a.
   function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'b1000000: res = 5'b1_0000;
         7'b1111001: res = 5'b1_0001;
         7'b0100100: res = 5'b1_0010;
         7'b0110000: res = 5'b1_0011;
         7'b0011001: res = 5'b1_0100;
         7'b0010010: res = 5'b1_0101;
         7'b0000010: res = 5'b1_0110;
         7'b1111000: res = 5'b1_0111;
         7'b0000000: res = 5'b1_1000;
         7'b0010000: res = 5'b1_1001;
         7'b0001000: res = 5'b1_1010;
         7'b0000011: res = 5'b1_1011;
         7'b1000110: res = 5'b1_1100;
         7'b0100001: res = 5'b1_1101;
         7'b0000110: res = 5'b1_1110;
         7'b0001110: res = 5'b1_1111;
         default:    res = 5'b0_0000;
      endcase
      return res;
   endfunction

   logic [10:0]      tuple_r, prev_r;
   logic [CNT_W-1:0] hold_r, to_r;
   state_t           state_r;
   logic [3:0]       seen_r, valid_r;
   logic [3:0]       char_r [4];
   logic             frame_r, multi_r, segerr_r;

   logic             changed_s, capture_s, single_s, multi_s, blank_s;
   logic [3:0]       low_s, seen_next_s;
   logic [1:0]       idx_s;
   logic [4:0]       glyph_s;

   // Capture qualification and digit decode of the registered tuple.
   always_comb begin
      low_s       = ~tuple_r[10:7];
      changed_s   = (tuple_r != prev_r);
      capture_s   = !changed_s && (hold_r == HOLD_FIRE);
      single_s    = $onehot(low_s);
      multi_s     = (low_s != 4'b0000) && !single_s;
      glyph_s     = glyph_decode(tuple_r[6:0]);
      blank_s     = (tuple_r[6:0] == 7'b1111111);
      seen_next_s = seen_r | low_s;
      case (low_s)
         4'b0001: idx_s = 2'd0;
         4'b0010: idx_s = 2'd1;
         4'b0100: idx_s = 2'd2;
         4'b1000: idx_s = 2'd3;
         default: idx_s = 2'd0;
      endcase
   end

   // Input sampling and the dwell (hold) counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         tuple_r <= 11'd0;
         prev_r  <= 11'd0;
         hold_r  <= '0;
      end else begin
         tuple_r <= {an3, an2, an1, an0, g, f, e, d, c, b, a};
         prev_r  <= tuple_r;
         if (changed_s) begin
            hold_r <= '0;
         end else if (hold_r != CNT_MAX) begin
            hold_r <= hold_r + CNT_ONE;
         end else begin
            hold_r <= hold_r;
         end
      end
   end

   // Scan FSM: character update, frame tracking, timeout and error pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         to_r     <= '0;
         seen_r   <= 4'b0000;
         valid_r  <= 4'b0000;
         frame_r  <= 1'b0;
         multi_r  <= 1'b0;
         segerr_r <= 1'b0;
         for (int i = 0; i < 4; i++) char_r[i] <= 4'h0;
      end else begin
         frame_r  <= 1'b0;
         multi_r  <= 1'b0;
         segerr_r <= 1'b0;
         if (capture_s && single_s) begin
            state_r <= SCAN;
            to_r    <= '0;
            if (glyph_s[4]) begin
               char_r[idx_s]  <= glyph_s[3:0];
               valid_r[idx_s] <= 1'b1;
            end else begin
               valid_r[idx_s] <= 1'b0;
               segerr_r       <= !blank_s;
            end
            if (seen_next_s == 4'b1111) begin
               frame_r <= 1'b1;
               seen_r  <= 4'b0000;
            end else begin
               seen_r  <= seen_next_s;
            end
         end else begin
            multi_r <= capture_s && multi_s;
            if (state_r == SCAN) begin
               if (to_r == TO_FIRE) begin
                  valid_r <= 4'b0000;
                  seen_r  <= 4'b0000;
                  state_r <= IDLE;
                  to_r    <= '0;
               end else if (to_r != CNT_MAX) begin
                  to_r <= to_r + CNT_ONE;
               end else begin
                  to_r <= to_r;
               end
            end else begin
               to_r <= '0;
            end
         end
      end
   end

   assign char0      = char_r[0];
   assign char1      = char_r[1];
   assign char2      = char_r[2];
   assign char3      = char_r[3];
   assign char_valid = valid_r;
   assign frame_done = frame_r;
   assign err_multi  = multi_r;
   assign err_seg    = segerr_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder.
// Expected captures are queued when a dwell is driven and checked on the cycle the outputs must change.
module tb_seg7_scan_decoder;

   localparam int MIN_HOLD = 16;
   localparam int TIMEOUT  = 65536;

   logic clk = 1'b0;
   logic reset;
   logic an3, an2, an1, an0, a, b, c, d, e, f, g;
   logic [3:0] char3, char2, char1, char0, char_valid;
   logic frame_done, err_multi, err_seg;

   seg7_scan_decoder #(.MIN_HOLD(MIN_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(17)) dut (
      .clk(clk), .reset(reset),
      .an3(an3), .an2(an2), .an1(an1), .an0(an0),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .char3(char3), .char2(char2), .char1(char1), .char0(char0),
      .char_valid(char_valid), .frame_done(frame_done),
      .err_multi(err_multi), .err_seg(err_seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          at;
      logic [22:0] exp;
      string       tag;
   } ev_t;

   ev_t         q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [3:0]  m_char [4];
   logic [3:0]  m_valid, m_seen;
   int          m_last;
   logic [22:0] cur;
   logic [6:0]  glyph_tab [16];

   function automatic logic [22:0] pack(input logic fd, input logic em, input logic es);
      return {m_char[3], m_char[2], m_char[1], m_char[0], m_valid, fd, em, es};
   endfunction

   task automatic drive(input logic [3:0] an, input logic [6:0] seg);
      {an3, an2, an1, an0} = an;
      {g, f, e, d, c, b, a} = seg;
   endtask

   task automatic check(input string tag, input logic [22:0] exp);
      logic [22:0] obs;
      obs = {char3, char2, char1, char0, char_valid, frame_done, err_multi, err_seg};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input string tag);
      ev_t ev;
      @(negedge clk);
      cyc++;
      if (q.size() > 0 && q[0].at == cyc) begin
         ev  = q.pop_front();
         cur = {ev.exp[22:3], 3'b000};
         check(ev.tag, ev.exp);
      end else begin
         check(tag, cur);
      end
   endtask

   task automatic model_capture(input logic [3:0] an, input logic [6:0] seg, input int at, input string tag);
      logic [3:0] low;
      logic       fd, em, es, hit;
      int         idx, val;
      ev_t        ev;
      low = ~an;
      fd = 1'b0; em = 1'b0; es = 1'b0; hit = 1'b0; idx = 0; val = 0;
      if (low == 4'b0000) return;
      if ($onehot(low)) begin
         for (int k = 0; k < 4; k++) if (low[k]) idx = k;
         for (int v = 0; v < 16; v++) if (glyph_tab[v] == seg) begin hit = 1'b1; val = v; end
         if (hit) begin
            m_char[idx]  = 4'(val);
            m_valid[idx] = 1'b1;
         end else begin
            m_valid[idx] = 1'b0;
            es = (seg != 7'b1111111);
         end
         m_seen[idx] = 1'b1;
         m_last = at;
         if (m_seen == 4'b1111) begin
            fd = 1'b1;
            m_seen = 4'b0000;
         end
      end else begin
         em = 1'b1;
      end
      ev.at = at; ev.exp = pack(fd, em, es); ev.tag = tag;
      q.push_back(ev);
   endtask

   task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n, input string tag);
      drive(an, seg);
      if (n >= MIN_HOLD) model_capture(an, seg, cyc + MIN_HOLD + 1, tag);
      repeat (n) step(tag);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_char[i] = 4'h0;
      m_valid = 4'b0000;
      m_seen  = 4'b0000;
      cur     = 23'd0;
   endtask

   initial begin
      ev_t ev;
      glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      model_reset();
      m_last = 0;

      // reset with random inputs
      reset = 1'b1;
      repeat (3) begin
         drive(4'($urandom), 7'($urandom));
         step("reset");
      end
      reset = 1'b0;

      // first frame 1,2,3,4
      dwell(4'b1110, glyph_tab[1], 20, "frame1_d0");
      dwell(4'b1101, glyph_tab[2], 20, "frame1_d1");
      dwell(4'b1011, glyph_tab[3], 20, "frame1_d2");
      dwell(4'b0111, glyph_tab[4], 20, "frame1_d3");

      // short dwells, then the exact hold boundary
      dwell(4'b1101, glyph_tab[14], 10, "short_dwell");
      dwell(4'b1111, 7'b1111111, 5, "gap");
      dwell(4'b1101, glyph_tab[9], MIN_HOLD - 1, "hold_minus1");
      dwell(4'b1101, glyph_tab[8], MIN_HOLD, "hold_exact");

      // multiple anodes, illegal pattern, blank digit
      dwell(4'b1100, 7'b0000000, 20, "multi_anode");
      dwell(4'b1110, 7'b0110110, 20, "bad_glyph");
      dwell(4'b1011, 7'b1111111, 20, "blank_digit");

      // second frame A,b,C,d completes the seen mask
      dwell(4'b1110, glyph_tab[10], 20, "frame2_d0");
      dwell(4'b1101, glyph_tab[11], 20, "frame2_d1");
      dwell(4'b1011, glyph_tab[12], 20, "frame2_d2");
      dwell(4'b0111, glyph_tab[13], 20, "frame2_d3");

      // timeout with all anodes high
      m_valid = 4'b0000;
      m_seen  = 4'b0000;
      ev.at = m_last + TIMEOUT - 1; ev.exp = pack(1'b0, 1'b0, 1'b0); ev.tag = "timeout";
      q.push_back(ev);
      dwell(4'b1111, 7'b1111111, TIMEOUT + 20, "timeout_wait");

      // reset in the middle of a dwell discards it
      dwell(4'b1110, glyph_tab[7], 8, "pre_reset");
      reset = 1'b1;
      model_reset();
      repeat (2) step("mid_reset");
      reset = 1'b0;
      dwell(4'b1111, 7'b1111111, 30, "post_reset");

      total++;
      assert (q.size() === 0) else begin
         bad++;
         $error("FAIL queue_drained: observed=%0d pending expected=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
